// File: rtl/reg_file_sb.sv
// reg_file_sb: 2-read / 1-write register file with a busy scoreboard.
//
// Each read port is registered. When rdEn is high the port captures the
// addressed register and its valid flag. A same-edge write to the same
// address is bypassed (write-first), so the port captures C rather than the
// old contents. Each register has a busy bit. A reservation from decode
// sets it, a writeback load clears it, and flush clears every busy bit.
// When ZERO_REG = 1, register 0 always reads as zero and is never busy.
//
// Ports:
//   clk              rising-edge clock
//   clear            asynchronous active-high reset
//   rdEn             capture new A/B/Avalid/Bvalid this edge (else hold)
//   Aaddr, Baddr     read addresses
//   A, B             registered read data
//   Avalid, Bvalid   registered; 1 = captured value is final (register not busy)
//   load, Caddr, C   write enable, write address, write data
//   rsv, rsvAddr     reserve (mark busy) register rsvAddr
//   flush            synchronous clear of all busy bits (data untouched)
//   anyBusy          combinational OR of the current busy vector
//
// Handshake: there is no valid/ready flow control. Every request is taken on
// the edge where its enable is high. Avalid/Bvalid only qualify the data;
// they do not back-pressure anything.
module reg_file_sb #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 4,
  parameter int ZERO_REG = 0
) (
  input  logic              clk,
  input  logic              clear,
  input  logic              rdEn,
  input  logic [ADDR_W-1:0] Aaddr,
  input  logic [ADDR_W-1:0] Baddr,
  output logic [DATA_W-1:0] A,
  output logic [DATA_W-1:0] B,
  output logic              Avalid,
  output logic              Bvalid,
  input  logic              load,
  input  logic [ADDR_W-1:0] Caddr,
  input  logic [DATA_W-1:0] C,
  input  logic              rsv,
  input  logic [ADDR_W-1:0] rsvAddr,
  input  logic              flush,
  output logic              anyBusy
);

  localparam int DEPTH    = 1 << ADDR_W;
  localparam bit HAS_ZERO = (ZERO_REG != 0);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DEPTH-1:0]  busy_q, busy_d;
  logic [DATA_W-1:0] a_q, a_d, b_q, b_d;
  logic              av_q, av_d, bv_q, bv_d;
  logic              wr_en, rsv_en;

  // The hardwired zero register swallows writes and reservations.
  assign wr_en  = load && !(HAS_ZERO && (Caddr == '0));
  assign rsv_en = rsv && !(HAS_ZERO && (rsvAddr == '0));

  // Next busy vector. The assignment order gives flush > rsv > load.
  always_comb begin
    busy_d = busy_q;
    if (flush) begin
      busy_d = '0;
    end else begin
      if (wr_en)  busy_d[Caddr]   = 1'b0;
      if (rsv_en) busy_d[rsvAddr] = 1'b1;
    end
  end

  // Read data with write-first bypass against the same-edge write.
  function automatic logic [DATA_W-1:0] rd_data(
    input logic [ADDR_W-1:0] addr,
    input logic              we,
    input logic [ADDR_W-1:0] waddr,
    input logic [DATA_W-1:0] wdata,
    input logic [DATA_W-1:0] stored
  );
    if (HAS_ZERO && (addr == '0)) return '0;
    if (we && (waddr == addr))    return wdata;
    return stored;
  endfunction

  always_comb begin
    a_d  = a_q;
    b_d  = b_q;
    av_d = av_q;
    bv_d = bv_q;
    if (rdEn) begin
      a_d  = rd_data(Aaddr, wr_en, Caddr, C, mem_q[Aaddr]);
      b_d  = rd_data(Baddr, wr_en, Caddr, C, mem_q[Baddr]);
      // Valid reflects the post-edge busy state, so a same-edge rsv/load/flush
      // is already visible. busy_d[0] is never set when HAS_ZERO.
      av_d = ~busy_d[Aaddr];
      bv_d = ~busy_d[Baddr];
    end
  end

  always_ff @(posedge clk or posedge clear) begin
    if (clear) begin
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
      busy_q <= '0;
      a_q    <= '0;
      b_q    <= '0;
      av_q   <= 1'b1;
      bv_q   <= 1'b1;
    end else begin
      if (wr_en) mem_q[Caddr] <= C;
      busy_q <= busy_d;
      a_q    <= a_d;
      b_q    <= b_d;
      av_q   <= av_d;
      bv_q   <= bv_d;
    end
  end

  assign A       = a_q;
  assign B       = b_q;
  assign Avalid  = av_q;
  assign Bvalid  = bv_q;
  assign anyBusy = |busy_q;

endmodule
